seq_bin_to_bcd: RTL and testbench
=================================

Name: seq_bin_to_bcd

Overview:
Multi-cycle double-dabble (shift-add-3) converter from two's-complement binary to sign plus packed BCD. It sits between the Booth multiplier product and the 7-segment display controller: it captures the 16-bit product Y on a start pulse and presents decimal digits plus a sign flag to the display.

Parameters:
WIDTH, 16, bit width of binary input.
DIGITS, 5, number of BCD digits produced; 5 covers full 16-bit magnitude.
SIGNED, 1, 1 = input is two's complement (sign/magnitude out); 0 = input is unsigned.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  conversion request; sampled only in IDLE.
binario  input  WIDTH  value to convert; sampled on the accepted start cycle only.
busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive.
done  output  1  single-cycle pulse when bcd, neg and ovf update.
bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
neg  output  1  sign of last converted value (1 = negative); always 0 when SIGNED=0.
ovf  output  1  last conversion lost a nonzero carry beyond digit DIGITS-1.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, bcd=0, neg=0, ovf=0, shift counter=0, scratch registers=0. Reset aborts any conversion in progress; no done pulse follows.
- States: IDLE, SHIFT, FINISH.
- IDLE: if start=1, load magnitude register with |binario| (SIGNED=1) or binario (SIGNED=0), clear BCD scratch and overflow sticky, set neg_scratch=binario[WIDTH-1] & SIGNED, counter=WIDTH, go to SHIFT. Otherwise stay.
- Magnitude: computed in WIDTH bits as unsigned. The most negative value, e.g. -32768 for WIDTH=16, maps to magnitude 2^(WIDTH-1) and must convert correctly.
- SHIFT, one iteration per cycle:
  - Every scratch digit >=5 gets +3.
  - Then {scratch, magnitude} shifts left by 1; the magnitude MSB enters digit 0 LSB.
  - A 1 shifted out of the top digit sets the overflow sticky.
  - Decrement counter. When counter reaches 1 before the decrement, go to FINISH.
  - There are exactly WIDTH SHIFT cycles.
- FINISH: register bcd<=scratch, neg<=neg_scratch, ovf<=sticky; done=1 for this cycle only; next state IDLE.
- Zero result: neg forced to 0 (no "-0").
- Latency: start accepted at edge N; done high during cycle N+WIDTH+1 (17 cycles for WIDTH=16). Outputs valid from that same cycle and held until the next FINISH.
- Throughput: next start is accepted in the first IDLE cycle after FINISH, giving WIDTH+2 cycles per conversion.
- busy is 1 in SHIFT and FINISH, 0 in IDLE.
- start while busy=1 is ignored and not queued. start held high continuously produces back-to-back conversions, each re-sampling binario.
- binario changes after acceptance do not affect the conversion in progress.
- bcd, neg and ovf never change except in FINISH or reset; no glitching to intermediate scratch values.
- Every output digit is in 0..9 for all inputs.

Test Plan:
- Reset then start with binario=16'h0000 -> done 17 cycles later; bcd=20'h00000, neg=0, ovf=0, busy low the next cycle.
- binario=16'd1234 -> bcd=20'h01234, neg=0. Then binario=16'hC000 (-16384) -> bcd=20'h16384, neg=1.
- binario=16'h8000 with SIGNED=1 -> bcd=20'h32768, neg=1. Same input with SIGNED=0 -> bcd=20'h32768, neg=0. With SIGNED=0, 16'hFFFF -> bcd=20'h65535.
- Start 1234, then pulse start with binario=999 at cycles +3 and +17 (the FINISH cycle) -> both ignored; exactly one done pulse with bcd=20'h01234; prior bcd held until that done.
- Start conversion of 4321, assert rst at cycle +8 -> all outputs 0, no done pulse. A fresh start of 4321 then completes normally with bcd=20'h04321.
- DIGITS=4, binario=16'd12345 -> done with ovf=1, bcd=16'h2345. A following binario=16'd9999 -> ovf=0, bcd=16'h9999.

Source files
------------

// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd
// Multi-cycle double-dabble (shift-add-3) converter from binary to sign plus
// packed BCD. A start pulse in IDLE captures binario; WIDTH shift iterations
// later the result is published on bcd/neg/ovf together with a one-cycle
// done pulse. The published outputs hold until the next completed conversion.
//
// Ports:
//   clk      system clock, rising-edge active
//   rst      synchronous reset, active-high; aborts any conversion in progress
//   start    conversion request, honoured only while idle
//   binario  value to convert, captured on the accepted start cycle
//   busy     high while a conversion is in flight, including the done cycle
//   done     single-cycle pulse in the cycle the new result becomes visible
//   bcd      packed BCD result, digit 0 (units) in bits [3:0]
//   neg      result sign (1 = negative); never set for a zero result
//   ovf      a nonzero carry was lost beyond the top digit
module seq_bin_to_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binario,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MAG_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   scratch;
  logic               sticky;
  logic               neg_s;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nx;
  logic               carry;

  // Every digit >= 5 gets +3 so that the following doubling carries into the
  // next decimal digit instead of producing a nibble value of 10..15.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Unsigned magnitude in WIDTH bits; the most negative input wraps to
  // 2^(WIDTH-1), which is exactly its magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (SIGNED && (sv < 0)) return ~v + MAG_ONE;
    return v;
  endfunction

  assign adj        = add3_digits(scratch);
  assign scratch_nx = {adj[BCD_W-2:0], mag[WIDTH-1]};
  assign carry      = adj[BCD_W-1];

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_ONE) state_nx = FINISH;
      end
      FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mag     <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      neg_s   <= 1'b0;
      bcd     <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= magnitude(binario);
            scratch <= '0;
            sticky  <= 1'b0;
            // A negative input is never zero, but keep the guard explicit.
            neg_s   <= binario[WIDTH-1] & SIGNED & (|binario);
            cnt     <= CNT_INIT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nx;
          mag     <= {mag[WIDTH-2:0], 1'b0};
          sticky  <= sticky | carry;
          cnt     <= cnt - CNT_ONE;
          // Publish on the last iteration so the result is visible in the
          // same cycle that done is high (the FINISH cycle).
          if (cnt == CNT_ONE) begin
            bcd <= scratch_nx;
            neg <= neg_s;
            ovf <= sticky | carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
module tb_seq_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bin = '0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic        busy0, done0, neg0, ovf0;
  logic [19:0] bcd0;
  logic        busy1, done1, neg1, ovf1;
  logic [19:0] bcd1;
  logic        busy2, done2, neg2, ovf2;
  logic [15:0] bcd2;

  int total = 0;
  int bad   = 0;
  int cur_sel = 0;

  logic        busy_m, done_m, neg_m, ovf_m;
  logic [19:0] bcd_m;

  always #5 clk = ~clk;

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .binario(bin),
    .busy(busy0), .done(done0), .bcd(bcd0), .neg(neg0), .ovf(ovf0));

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(start1), .binario(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .neg(neg1), .ovf(ovf1));

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .start(start2), .binario(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .neg(neg2), .ovf(ovf2));

  always_comb begin
    busy_m = busy0; done_m = done0; neg_m = neg0; ovf_m = ovf0; bcd_m = bcd0;
    case (cur_sel)
      1: begin busy_m = busy1; done_m = done1; neg_m = neg1; ovf_m = ovf1; bcd_m = bcd1; end
      2: begin busy_m = busy2; done_m = done2; neg_m = neg2; ovf_m = ovf2; bcd_m = {4'h0, bcd2}; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    start0 = (sel == 0) ? v : 1'b0;
    start1 = (sel == 1) ? v : 1'b0;
    start2 = (sel == 2) ? v : 1'b0;
  endtask

  // Start one conversion on the selected instance, then check latency,
  // busy, result and the idle cycle that follows.
  task automatic convert(input int sel, input logic [15:0] v, input logic [19:0] eb,
                         input logic en, input logic eo, input string tag);
    int n;
    cur_sel = sel;
    bin = v;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    bin = 16'h5A5A;
    n = 1;
    chk({tag, "_busy"}, 32'(busy_m), 32'd1);
    while (!done_m && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd17);
    chk({tag, "_bcd"}, 32'(bcd_m), 32'(eb));
    chk({tag, "_neg"}, 32'(neg_m), 32'(en));
    chk({tag, "_ovf"}, 32'(ovf_m), 32'(eo));
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(done_m), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy_m), 32'd0);
    chk({tag, "_bcd_hold"}, 32'(bcd_m), 32'(eb));
  endtask

  initial begin
    int pulses;
    int done_at;
    logic held_ok;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      cur_sel = s;
      #0;
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
      chk("rst_bcd",  32'(bcd_m),  32'd0);
      chk("rst_neg",  32'(neg_m),  32'd0);
      chk("rst_ovf",  32'(ovf_m),  32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    convert(0, 16'h0000, 20'h00000, 1'b0, 1'b0, "zero");
    convert(0, 16'd1234, 20'h01234, 1'b0, 1'b0, "p1234");
    convert(0, 16'hC000, 20'h16384, 1'b1, 1'b0, "m16384");
    convert(0, 16'h8000, 20'h32768, 1'b1, 1'b0, "m32768");
    convert(1, 16'h8000, 20'h32768, 1'b0, 1'b0, "u32768");
    convert(1, 16'hFFFF, 20'h65535, 1'b0, 1'b0, "u65535");

    // Starts during a conversion (including its FINISH cycle) are dropped.
    cur_sel = 0;
    bin = 16'd1234;
    start0 = 1'b1;
    pulses = 0;
    done_at = 0;
    held_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done0) begin
        pulses++;
        done_at = k;
      end
      if (k < 17 && bcd0 !== 20'h32768) held_ok = 1'b0;
      if (k == 17) begin
        chk("ign_done", 32'(done0), 32'd1);
        chk("ign_bcd",  32'(bcd0),  32'h01234);
      end
      start0 = (k == 3 || k == 17);
      bin    = (k == 3 || k == 17) ? 16'd999 : 16'd1234;
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_done_at", 32'(done_at), 32'd17);
    chk("ign_prior_held", 32'(held_ok), 32'd1);
    chk("ign_bcd_final", 32'(bcd0), 32'h01234);
    chk("ign_busy_idle", 32'(busy0), 32'd0);

    // Reset mid-conversion aborts without a done pulse.
    bin = 16'd4321;
    start0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (k == 8) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_bcd",  32'(bcd0),  32'd0);
    chk("abort_neg",  32'(neg0),  32'd0);
    chk("abort_ovf",  32'(ovf0),  32'd0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    convert(0, 16'd4321, 20'h04321, 1'b0, 1'b0, "p4321");

    // Four-digit instance: 12345 loses its ten-thousands digit.
    convert(2, 16'd12345, 20'h02345, 1'b0, 1'b1, "d4_ovf");
    convert(2, 16'd9999,  20'h09999, 1'b0, 1'b0, "d4_9999");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
